adc_result_fifo: RTL and testbench
==================================

ADC_RESULT_FIFO -- requirements
Module: adc_result_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the result word width.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of FIFO entries; DEPTH SHALL be a power of two, at least 2.
REQ-003 The block SHALL have port clk_dig_in  input  1  digital clock, rising-edge active.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port result_in  input  WIDTH  conversion result, driven by the core result_out.
REQ-006 The block SHALL have port conv_finished_in  input  1  result-ready level, driven by the core conv_finished_osr_out.
REQ-007 The block SHALL have port clear_in  input  1  synchronous flush.
REQ-008 The block SHALL have port ready_in  input  1  consumer accepts the head word.
REQ-009 The block SHALL have port data_out  output  WIDTH  head-of-FIFO result.
REQ-010 The block SHALL have port valid_out  output  1  data_out holds a valid word.
REQ-011 The block SHALL have port level_out  output  log2(DEPTH)+1  current occupancy.
REQ-012 The block SHALL have ports full_out and empty_out  output  1 each  occupancy flags.
REQ-013 The block SHALL have port overflow_out  output  1  sticky flag: a result was dropped.

Function
REQ-014 A push SHALL occur on the clock edge where conv_finished_in samples 1 and its registered previous value is 0 (rising-edge detect).
REQ-015 A pushed word SHALL be result_in as sampled on that same edge; valid_out SHALL rise one cycle after the push (1-cycle latency from empty).
REQ-016 data_out SHALL be show-ahead: equal to the oldest stored entry whenever valid_out=1, and 0 when empty.
REQ-017 A pop SHALL occur on an edge where valid_out=1 and ready_in=1; ready_in while empty SHALL have no effect.
REQ-018 Push and pop on the same edge SHALL both complete: level unchanged when non-empty, including when full.
REQ-019 A push while full without a simultaneous pop SHALL be dropped, contents unchanged, and overflow_out SHALL be set.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; level_out SHALL range 0..DEPTH; full_out = (level_out==DEPTH), empty_out = (level_out==0), valid_out = !empty_out.
REQ-021 clear_in=1 SHALL empty the FIFO and clear overflow_out on that edge, with priority over any push or pop on the same edge; the edge-detect register SHALL still update.
REQ-022 conv_finished_in held high for multiple cycles SHALL yield exactly one push.

Reset
REQ-023 On rst_n=0 all pointers and level SHALL be 0, valid_out=0, full_out=0, empty_out=1, overflow_out=0, data_out=0, asynchronously.
REQ-024 The edge-detect register SHALL reset to 1, so conv_finished_in high at reset release does not cause a push.
REQ-025 Storage array contents need not be reset.

Configuration
REQ-026 Macro ADC_RESULT_FIFO_TAG_EN SHALL, when defined, add output tag_out (4 bits): a wrapping sequence tag stored with each entry, taken from a counter that increments on every detected edge including dropped pushes and resets to 0 on rst_n or clear_in.
REQ-027 Without ADC_RESULT_FIFO_TAG_EN, the port tag_out, the counter and tag storage SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package adc_result_pkg SHALL hold the WIDTH and DEPTH defaults, TAG_W=4 and the derived pointer width constant.
REQ-029 Storage SHALL be a sub-module adc_result_fifo_mem (1 write port, 1 asynchronous read port); control SHALL remain in adc_result_fifo.

Verification
REQ-030 Reset release with conv_finished_in=1 -> no push; empty_out=1, level_out=0.
REQ-031 Three edges with result_in 0x3CC0, 0x64C0, 0x0040, ready_in=0 -> level_out=3; then ready_in=1 -> data_out 0x3CC0, 0x64C0, 0x0040 on consecutive cycles, then empty_out=1.
REQ-032 Nine edges with DEPTH=8, ready_in=0 -> full_out=1, level_out=8, overflow_out=1, ninth value absent from readout.
REQ-033 When full, a push and a pop on the same edge -> level_out stays 8, overflow_out stays 0, new word read out last.
REQ-034 clear_in coincident with push while 5 entries held -> level_out=0, overflow_out=0, no entry stored.
REQ-035 With ADC_RESULT_FIFO_TAG_EN: 10 edges at DEPTH=8 with no reads -> stored tags 0..7, drained tags 0..7, next push gets tag 10.

Source files
------------

// File: rtl/adc_result_pkg.sv
// Shared constants for the ADC result FIFO: default geometry, tag width and
// the derived pointer width.
package adc_result_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int TAG_W     = 4;

    // Pointer width for a power-of-two depth; never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    localparam int PTR_W_DEF = ptr_width(DEPTH_DEF);

endpackage

// File: rtl/adc_result_fifo_mem.sv
// Storage array for the ADC result FIFO: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module adc_result_fifo_mem #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clk_dig_in,
    input  logic          wr_en_in,
    input  logic [AW-1:0] wr_addr_in,
    input  logic [DW-1:0] wr_data_in,
    input  logic [AW-1:0] rd_addr_in,
    output logic [DW-1:0] rd_data_out
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_dig_in) begin
        if (wr_en_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
    end

    assign rd_data_out = mem_q[rd_addr_in];

endmodule

// File: rtl/adc_result_fifo.sv
// Show-ahead FIFO capturing ADC results on each rising edge of the core's
// result-ready level. Define ADC_RESULT_FIFO_TAG_EN to add a per-entry sequence tag.
module adc_result_fifo
    import adc_result_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                          clk_dig_in,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              result_in,
    input  logic                          conv_finished_in,
    input  logic                          clear_in,
    input  logic                          ready_in,
    output logic [WIDTH-1:0]              data_out,
    output logic                          valid_out,
    output logic [ptr_width(DEPTH):0]     level_out,
    output logic                          full_out,
    output logic                          empty_out,
    output logic                          overflow_out
`ifdef ADC_RESULT_FIFO_TAG_EN
    ,
    output logic [TAG_W-1:0]              tag_out
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef ADC_RESULT_FIFO_TAG_EN
    localparam int MEM_W = WIDTH + TAG_W;
`else
    localparam int MEM_W = WIDTH;
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             conv_prev_q;

    logic             push_det;
    logic             is_empty;
    logic             is_full;
    logic             pop_req;
    logic             wr_en;
    logic             rd_en;
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] rd_word;

    always_comb begin
        push_det = conv_finished_in & ~conv_prev_q;
        is_empty = (level_q == '0);
        is_full  = (level_q == LVL_W'(DEPTH));
        pop_req  = ~is_empty & ready_in;
        // A push into a full FIFO only lands if the head leaves on the same edge.
        wr_en    = push_det & (~is_full | pop_req) & ~clear_in;
        rd_en    = pop_req & ~clear_in;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (clear_in) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (push_det && is_full && !pop_req) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_dig_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            // Starts high so a level already asserted at reset release is not a push.
            conv_prev_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            conv_prev_q <= conv_finished_in;
        end
    end

`ifdef ADC_RESULT_FIFO_TAG_EN
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;

    // Counts every detected edge, dropped pushes included.
    always_comb begin
        tag_cnt_d = tag_cnt_q;
        if (clear_in) begin
            tag_cnt_d = '0;
        end else if (push_det) begin
            tag_cnt_d = tag_cnt_q + TAG_W'(1);
        end
    end

    always_ff @(posedge clk_dig_in or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt_q <= '0;
        end else begin
            tag_cnt_q <= tag_cnt_d;
        end
    end

    assign wr_word = {tag_cnt_q, result_in};
    assign tag_out = is_empty ? '0 : rd_word[WIDTH +: TAG_W];
`else
    assign wr_word = result_in;
`endif

    adc_result_fifo_mem #(
        .DW    (MEM_W),
        .AW    (PTR_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_dig_in  (clk_dig_in),
        .wr_en_in    (wr_en),
        .wr_addr_in  (wr_ptr_q),
        .wr_data_in  (wr_word),
        .rd_addr_in  (rd_ptr_q),
        .rd_data_out (rd_word)
    );

    assign data_out     = is_empty ? '0 : rd_word[WIDTH-1:0];
    assign valid_out    = ~is_empty;
    assign level_out    = level_q;
    assign full_out     = is_full;
    assign empty_out    = is_empty;
    assign overflow_out = overflow_q;

endmodule

// File: tb/tb_adc_result_fifo.sv
// Directed testbench for adc_result_fifo at WIDTH=16, DEPTH=8; the tag test
// is included when ADC_RESULT_FIFO_TAG_EN is defined.
module tb_adc_result_fifo;

    logic        clk_dig_in = 1'b0;
    logic        rst_n;
    logic [15:0] result_in;
    logic        conv_finished_in;
    logic        clear_in;
    logic        ready_in;
    logic [15:0] data_out;
    logic        valid_out;
    logic [3:0]  level_out;
    logic        full_out;
    logic        empty_out;
    logic        overflow_out;
`ifdef ADC_RESULT_FIFO_TAG_EN
    logic [3:0]  tag_out;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk_dig_in = ~clk_dig_in;

    adc_result_fifo #(.WIDTH(16), .DEPTH(8)) dut (
        .clk_dig_in       (clk_dig_in),
        .rst_n            (rst_n),
        .result_in        (result_in),
        .conv_finished_in (conv_finished_in),
        .clear_in         (clear_in),
        .ready_in         (ready_in),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .level_out        (level_out),
        .full_out         (full_out),
        .empty_out        (empty_out),
        .overflow_out     (overflow_out)
`ifdef ADC_RESULT_FIFO_TAG_EN
        ,
        .tag_out          (tag_out)
`endif
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_dig_in);
        #1;
    endtask

    task automatic push(input logic [15:0] val);
        result_in        = val;
        conv_finished_in = 1'b1;
        step();
        conv_finished_in = 1'b0;
        step();
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        conv_finished_in = 1'b1;
        result_in = 16'hDEAD;
        #3;
        vectors++;
        if ({valid_out, full_out, empty_out, overflow_out, level_out, data_out} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_state: v/f/e/o=%b%b%b%b level=%0d data=%h, required 0010 level=0 data=0000",
                     valid_out, full_out, empty_out, overflow_out, level_out, data_out);
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        vectors++;
        if (empty_out !== 1'b1 || level_out !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_release_no_push: empty=%b level=%0d, required empty=1 level=0", empty_out, level_out);
        end
        conv_finished_in = 1'b0;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_order();
        logic [15:0] exp_q[3] = '{16'h3CC0, 16'h64C0, 16'h0040};
        foreach (exp_q[i]) push(exp_q[i]);
        vectors++;
        if (level_out !== 4'd3 || valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL order_level: level=%0d valid=%b, required level=3 valid=1", level_out, valid_out);
        end
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (data_out !== exp_q[i]) begin
                miscompares++;
                $display("FAIL order_data[%0d]: got %h, required %h", i, data_out, exp_q[i]);
            end
            step();
        end
        ready_in = 1'b0;
        vectors++;
        if (empty_out !== 1'b1 || data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL order_empty: empty=%b data=%h, required empty=1 data=0000", empty_out, data_out);
        end
        $display("test_order: done");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) push(16'h1000 + 16'(i));
        vectors++;
        if (full_out !== 1'b1 || level_out !== 4'd8 || overflow_out !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_flags: full=%b level=%0d ovf=%b, required full=1 level=8 ovf=1",
                     full_out, level_out, overflow_out);
        end
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (data_out !== 16'h1000 + 16'(i)) begin
                miscompares++;
                $display("FAIL overflow_data[%0d]: got %h, required %h", i, data_out, 16'h1000 + 16'(i));
            end
            step();
        end
        ready_in = 1'b0;
        vectors++;
        if (empty_out !== 1'b1 || overflow_out !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: empty=%b ovf=%b, required empty=1 ovf=1", empty_out, overflow_out);
        end
        do_clear();
        vectors++;
        if (overflow_out !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: ovf=%b, required 0", overflow_out);
        end
        $display("test_overflow: done");
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i));
        result_in        = 16'h2AAA;
        conv_finished_in = 1'b1;
        ready_in         = 1'b1;
        step();
        conv_finished_in = 1'b0;
        ready_in         = 1'b0;
        vectors++;
        if (level_out !== 4'd8 || overflow_out !== 1'b0 || data_out !== 16'h2001) begin
            miscompares++;
            $display("FAIL full_push_pop: level=%0d ovf=%b head=%h, required level=8 ovf=0 head=2001",
                     level_out, overflow_out, data_out);
        end
        step();
        ready_in = 1'b1;
        for (int i = 1; i < 9; i++) begin
            logic [15:0] exp_v;
            exp_v = (i == 8) ? 16'h2AAA : 16'h2000 + 16'(i);
            vectors++;
            if (data_out !== exp_v) begin
                miscompares++;
                $display("FAIL full_push_pop_data[%0d]: got %h, required %h", i, data_out, exp_v);
            end
            step();
        end
        ready_in = 1'b0;
        vectors++;
        if (empty_out !== 1'b1) begin
            miscompares++;
            $display("FAIL full_push_pop_empty: empty=%b, required 1", empty_out);
        end
        $display("test_full_push_pop: done");
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) push(16'h3000 + 16'(i));
        vectors++;
        if (level_out !== 4'd5) begin
            miscompares++;
            $display("FAIL clear_prefill: level=%0d, required 5", level_out);
        end
        result_in        = 16'h5555;
        conv_finished_in = 1'b1;
        do_clear();
        vectors++;
        if (level_out !== 4'd0 || overflow_out !== 1'b0 || empty_out !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_with_push: level=%0d ovf=%b empty=%b, required level=0 ovf=0 empty=1",
                     level_out, overflow_out, empty_out);
        end
        step();
        vectors++;
        if (level_out !== 4'd0) begin
            miscompares++;
            $display("FAIL clear_edge_reg: level=%0d, required 0 (held level must not push)", level_out);
        end
        conv_finished_in = 1'b0;
        step();
        $display("test_clear: done");
    endtask

    task automatic test_held_and_empty_pop();
        result_in        = 16'h7777;
        conv_finished_in = 1'b1;
        for (int i = 0; i < 4; i++) step();
        conv_finished_in = 1'b0;
        step();
        vectors++;
        if (level_out !== 4'd1 || data_out !== 16'h7777) begin
            miscompares++;
            $display("FAIL held_high: level=%0d data=%h, required level=1 data=7777", level_out, data_out);
        end
        ready_in = 1'b1;
        step();
        step();
        step();
        vectors++;
        if (level_out !== 4'd0 || empty_out !== 1'b1) begin
            miscompares++;
            $display("FAIL pop_when_empty: level=%0d empty=%b, required level=0 empty=1", level_out, empty_out);
        end
        ready_in = 1'b0;
        push(16'h8888);
        vectors++;
        if (level_out !== 4'd1 || data_out !== 16'h8888) begin
            miscompares++;
            $display("FAIL after_empty_pop: level=%0d data=%h, required level=1 data=8888", level_out, data_out);
        end
        do_clear();
        $display("test_held_and_empty_pop: done");
    endtask

`ifdef ADC_RESULT_FIFO_TAG_EN
    task automatic test_tag();
        do_clear();
        for (int i = 0; i < 10; i++) push(16'h4000 + 16'(i));
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (tag_out !== 4'(i) || data_out !== 16'h4000 + 16'(i)) begin
                miscompares++;
                $display("FAIL tag_drain[%0d]: tag=%0d data=%h, required tag=%0d data=%h",
                         i, tag_out, data_out, i, 16'h4000 + 16'(i));
            end
            step();
        end
        ready_in = 1'b0;
        push(16'h4ABC);
        vectors++;
        if (tag_out !== 4'd10 || data_out !== 16'h4ABC) begin
            miscompares++;
            $display("FAIL tag_next: tag=%0d data=%h, required tag=10 data=4abc", tag_out, data_out);
        end
        do_clear();
        $display("test_tag: done");
    endtask
`endif

    initial begin
        clear_in         = 1'b0;
        ready_in         = 1'b0;
        conv_finished_in = 1'b0;
        result_in        = '0;
        test_reset();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_held_and_empty_pop();
`ifdef ADC_RESULT_FIFO_TAG_EN
        test_tag();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
